// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand-forming skid-buffer stage ahead of the ALU
//
// Purpose:
//   Forms operand A (rs_data) and operand B (rt_data, or the sign-/zero-extended
//   immediate), then registers them with func_in behind a two-entry skid buffer.
//   The main entry drives the outputs. The skid entry absorbs one extra operand
//   set when the ALU stalls, so upstream backpressure never loses data.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           synchronous flush; empties both entries and drops same-cycle input
//   in_valid/in_ready                  upstream handshake
//   rs_data, rt_data, imm, use_imm,
//   sign_ext, func_in                  decoded operands and function select
//   out_valid/out_ready                downstream handshake
//   input1, input2, func_out           registered operands and function select to the ALU
//
// Optional feature (macro OPERAND_FWD_EN):
//   Adds the ports rs_idx, rt_idx, wb_en, wb_idx and wb_data.
//   When the macro is defined, a writeback to a register that matches a source
//   index replaces that register operand at capture. Register 0 never forwards.

module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int FUNC_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic [FUNC_W-1:0] func_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [FUNC_W-1:0] func_out
`ifdef OPERAND_FWD_EN
  ,
  input  logic [4:0]        rs_idx,
  input  logic [4:0]        rt_idx,
  input  logic              wb_en,
  input  logic [4:0]        wb_idx,
  input  logic [DATA_W-1:0] wb_data
`endif
);

  // Skid entry storage; the main entry is the output registers themselves.
  logic              skid_valid;
  logic [DATA_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_b;
  logic [FUNC_W-1:0] skid_f;

  // Operands formed from the current inputs. They are captured only on accept.
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic accept;
  logic drain;

  // Width casts extend the immediate. When the cast operand is signed, the
  // extension copies the sign bit.
  always_comb begin
    imm_ext = '0;
    if (sign_ext) begin
      imm_ext = DATA_W'($signed(imm));
    end else begin
      imm_ext = DATA_W'(imm);
    end
  end

`ifdef OPERAND_FWD_EN
  logic fwd_a;
  logic fwd_b;

  // Register 0 is hardwired, so a writeback to it is never forwarded.
  assign fwd_a = wb_en && (wb_idx == rs_idx) && (wb_idx != 5'd0);
  assign fwd_b = wb_en && (wb_idx == rt_idx) && (wb_idx != 5'd0);
  assign reg_a = fwd_a ? wb_data : rs_data;
  assign reg_b = fwd_b ? wb_data : rt_data;
`else
  assign reg_a = rs_data;
  assign reg_b = rt_data;
`endif

  assign op_a = reg_a;
  assign op_b = use_imm ? imm_ext : reg_b;

  // in_ready depends only on skid occupancy, not on out_ready. This keeps the
  // upstream handshake free of any combinational path from the ALU side.
  assign in_ready = ~skid_valid & ~rst;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      input1     <= '0;
      input2     <= '0;
      func_out   <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_f     <= '0;
    end else if (flush) begin
      // Only the valid bits are cleared. The stale data is never observed
      // because out_valid is low.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // in_ready was low, so there is no accept this cycle.
        // The skid entry simply advances into the main entry.
        input1     <= skid_a;
        input2     <= skid_b;
        func_out   <= skid_f;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        input1    <= op_a;
        input2    <= op_b;
        func_out  <= func_in;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        input1    <= op_a;
        input2    <= op_b;
        func_out  <= func_in;
        out_valid <= 1'b1;
      end else begin
        // The main entry is stalled, so park the new operands in the skid entry.
        skid_a     <= op_a;
        skid_b     <= op_b;
        skid_f     <= func_in;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule
